// File: rtl/seg7_scan_ctrl.sv
// Eight-digit multiplexed 7-segment scan controller with a double-buffered digit store,
// frame-aligned commit and PWM brightness. Outputs are active-low.
module seg7_scan_ctrl #(
   parameter int unsigned SCAN_LOG2 = 13
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic [2:0] wr_addr,
   input  logic [3:0] wr_val,
   input  logic       wr_dp,
   input  logic       wr_blank,
   input  logic       commit,
   input  logic       bright_wr,
   input  logic [2:0] bright_val,
   input  logic       disp_on,
   output logic [7:0] en,
   output logic [7:0] dataout,
   output logic       commit_pending,
   output logic       frame_tick
);

   localparam int unsigned NDIG = 8;
   localparam int unsigned IDXW = 3;
   localparam int unsigned BRW  = 3;
   localparam int unsigned SEGW = 8;

   typedef struct packed {
      logic [3:0] val;
      logic       dp;
      logic       blank;
   } entry_t;

   localparam entry_t ENTRY_RST = '{val: 4'h0, dp: 1'b0, blank: 1'b1};

   logic [SCAN_LOG2-1:0] slot_cnt_q, slot_cnt_d;
   logic [IDXW-1:0]      digit_idx_q, digit_idx_d;
   logic [BRW-1:0]       bright_q, bright_d;
   logic                 pend_q, pend_d;
   logic                 tick_q, tick_d;
   logic [SEGW-1:0]      en_q, en_d;
   logic [SEGW-1:0]      dout_q, dout_d;
   entry_t [NDIG-1:0]    shadow_q, shadow_d;
   entry_t [NDIG-1:0]    active_q, active_d;

   logic   boundary_c;
   logic   lit_c;
   entry_t cur_c;

   // Segment pattern g..a, active-low, for a hex digit.
   function automatic logic [6:0] seg_decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // Scan counters, buffers, commit handshake and registered drive computation.
   always_comb begin
      slot_cnt_d  = slot_cnt_q + SCAN_LOG2'(1);
      digit_idx_d = digit_idx_q;
      shadow_d    = shadow_q;
      active_d    = active_q;
      pend_d      = pend_q;
      bright_d    = bright_q;
      en_d        = 8'hFF;
      dout_d      = 8'hFF;

      if (&slot_cnt_q) begin
         digit_idx_d = digit_idx_q + IDXW'(1);
      end
      boundary_c = (&slot_cnt_q) && (digit_idx_q == 3'd7);
      tick_d     = boundary_c;

      // The copy uses pre-edge shadow, so a same-cycle write waits for the next commit.
      if (boundary_c && (pend_q || commit)) begin
         active_d = shadow_q;
      end

      if (commit) begin
         pend_d = 1'b1;
      end
      if (boundary_c) begin
         pend_d = 1'b0;
      end

      if (wr_en) begin
         shadow_d[wr_addr] = '{val: wr_val, dp: wr_dp, blank: wr_blank};
      end

      if (bright_wr) begin
         bright_d = bright_val;
      end

      cur_c = active_q[digit_idx_q];
      lit_c = slot_cnt_q[SCAN_LOG2-1 -: 3] <= bright_q;

      if (disp_on && lit_c && !cur_c.blank) begin
         en_d   = ~(8'b1 << digit_idx_q);
         dout_d = {~cur_c.dp, seg_decode(cur_c.val)};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slot_cnt_q  <= '0;
         digit_idx_q <= '0;
         bright_q    <= 3'd7;
         pend_q      <= 1'b0;
         tick_q      <= 1'b0;
         en_q        <= 8'hFF;
         dout_q      <= 8'hFF;
         for (int i = 0; i < NDIG; i++) begin
            shadow_q[i] <= ENTRY_RST;
            active_q[i] <= ENTRY_RST;
         end
      end else begin
         slot_cnt_q  <= slot_cnt_d;
         digit_idx_q <= digit_idx_d;
         bright_q    <= bright_d;
         pend_q      <= pend_d;
         tick_q      <= tick_d;
         en_q        <= en_d;
         dout_q      <= dout_d;
         shadow_q    <= shadow_d;
         active_q    <= active_d;
      end
   end

   assign en             = en_q;
   assign dataout        = dout_q;
   assign commit_pending = pend_q;
   assign frame_tick     = tick_q;

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 The block SHALL provide parameter SCAN_LOG2, default 13, meaning log2 of clk cycles per digit slot (slot = 2^SCAN_LOG2 cycles, minimum 3).
REQ-002 Port clk input 1: the single clock; all state SHALL be updated on its rising edge.
REQ-003 Port rst input 1: reset, asynchronous and active-low.
REQ-004 Port wr_en input 1: write strobe to the shadow digit buffer.
REQ-005 Port wr_addr input 3: digit index 0..7 for the write.
REQ-006 Port wr_val input 4: hex value 0..F for the write.
REQ-007 Port wr_dp input 1: decimal point for the write (1 = lit).
REQ-008 Port wr_blank input 1: blank flag for the write (1 = digit dark).
REQ-009 Port commit input 1: single-cycle request to copy the shadow buffer into the active buffer.
REQ-010 Port bright_wr input 1: brightness load strobe.
REQ-011 Port bright_val input 3: brightness level 0..7.
REQ-012 Port disp_on input 1: display enable (0 = all dark).
REQ-013 Port en output 8: digit select, active-low, one-hot-zero.
REQ-014 Port dataout output 8: segments, active-low; bit7 = dp, bits6..0 = g..a.
REQ-015 Port commit_pending output 1: a commit is waiting for a frame boundary.
REQ-016 Port frame_tick output 1: one-cycle pulse at each frame boundary.

Function
REQ-017 slot_cnt (SCAN_LOG2 bits) SHALL increment every cycle and wrap to 0; digit_idx (3 bits) SHALL increment when slot_cnt wraps, 7 wrapping to 0.
REQ-018 A frame boundary SHALL be the cycle in which slot_cnt is all-ones and digit_idx = 7; frame_tick SHALL be 1 in the following cycle only.
REQ-019 Counters SHALL run regardless of disp_on, writes, or commits.
REQ-020 A write with wr_en = 1 SHALL update shadow entry wr_addr {val, dp, blank} at that edge; writes SHALL always be accepted, with no back-pressure.
REQ-021 commit = 1 SHALL set commit_pending at that edge; commit while already pending SHALL have no further effect.
REQ-022 At a frame boundary edge with commit_pending = 1 (or commit = 1 in that same cycle), all 8 active entries SHALL load the pre-edge shadow contents and commit_pending SHALL clear.
REQ-023 A write in the boundary cycle SHALL land in shadow only and SHALL NOT appear in active until the next commit.
REQ-024 bright_wr = 1 SHALL load bright_val into the brightness register at that edge, effective next cycle.
REQ-025 The digit is "lit-window" when slot_cnt[SCAN_LOG2-1:SCAN_LOG2-3] <= brightness (duty (brightness+1)/8).
REQ-026 en and dataout SHALL be registered, computed from pre-edge digit_idx, slot_cnt, active entry, brightness and disp_on (one-cycle latency).
REQ-027 When disp_on = 1, the lit-window holds and active[digit_idx].blank = 0: en SHALL be 0 at bit digit_idx with all other bits 1, and dataout = {~dp, seg(val)}.
REQ-028 In all other cases en SHALL be 8'hFF and dataout SHALL be 8'hFF.
REQ-029 seg() 0..F (bit7 = 1 shown) SHALL be C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E hex.

Reset
REQ-030 While rst = 0: slot_cnt = 0, digit_idx = 0, brightness = 7, commit_pending = 0, frame_tick = 0, en = 8'hFF, dataout = 8'hFF.
REQ-031 While rst = 0, all shadow and active entries SHALL be val = 0, dp = 0, blank = 1.
REQ-032 Reset asserted mid-frame or with a commit pending SHALL discard the pending commit; after release, scanning SHALL restart at digit 0, slot_cnt 0.

Verification (SCAN_LOG2 = 4, 16 cycles per slot)
REQ-033 Reset release, disp_on = 1, no writes -> en and dataout stay 8'hFF for 2 full frames (256 cycles); first frame_tick occurs 128 cycles after release.
REQ-034 Write addr 3 = {5, dp = 1, blank = 0}, commit -> from the first boundary, during digit 3 slot: en = F7, dataout = 12; commit_pending goes high, then clears at the boundary.
REQ-035 bright_val = 1 with digit 0 = {A, 0, 0} active -> en = FE for exactly the first 4 cycles of each 16-cycle digit-0 slot, FF for the other 12.
REQ-036 Write addr 0 = {7, 0, 0} plus commit, both in the boundary cycle -> copy happens at that edge with old shadow, pending clears; digit 0 shows 7 only after the next commit and boundary.
REQ-037 disp_on = 0 mid-slot -> en = FF from the next cycle while frame_tick spacing stays 128 cycles; rst pulse with commit pending -> commit_pending = 0 and outputs FF immediately.
